// File: rtl/ntt_mem_arbiter_pkg.sv
// Shared definitions for the NTT memory arbiter: FSM encodings, address word offset,
// port limits and counter widths.
package ntt_mem_arbiter_pkg;

    localparam int WORD_OFFSET = 3;
    localparam int MAX_PORTS   = 8;
    localparam int DATA_W      = 64;
    localparam int PERF_W      = 32;
    // Holds READ_LAT-2 for the largest supported latency of 8.
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GNT,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ntt_mem_arbiter_rr.sv
// Combinational round-robin picker: grants the first requester after 'last', wrapping.
// Shared with the command dispatcher, so it carries no state of its own.
module ntt_rr_arbiter
    import ntt_mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int IDX_W    = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] pick,
    output logic                 any
);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        pos   = '0;
        any   = |req;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            pos = IDX_W'((int'(last) + i) % NUM_PORTS);
            if (!found && req[pos]) begin
                pick[pos] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ntt_mem_arbiter.sv
// Round-robin responder for the ntt_core memory port, backed by a 64-bit scratch RAM.
// Define NTT_MEM_ARB_PERF_EN to add saturating grant and stall counters.
module ntt_mem_arbiter
    import ntt_mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*DATA_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        valid,
    output logic [DATA_W-1:0]           rdata
`ifdef NTT_MEM_ARB_PERF_EN
    ,
    output logic [NUM_PORTS*PERF_W-1:0] perf_grants,
    output logic [PERF_W-1:0]           perf_stall
`endif
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam int DEPTH = 1 << ADDR_W;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [NUM_PORTS-1:0] pick;
    logic               any;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   rr_last;
    logic [IDX_W-1:0]   sel_q;
    logic               we_q;
    logic [ADDR_W-1:0]  index_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  ram [DEPTH];
    logic [DATA_W-1:0]  rd_pipe [READ_LAT];
    logic               unused_addr;

    // Byte-address bits outside the word index are deliberately ignored.
    assign unused_addr = ^addr;

    ntt_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .req  (req),
        .last (rr_last),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        gnt        = '0;
        valid      = '0;
        rdata      = '0;
        case (state)
            ST_IDLE: begin
                if (any) state_next = ST_GNT;
            end
            ST_GNT: begin
                gnt[sel_q] = 1'b1;
                if (we_q) begin
                    state_next = ST_IDLE;
                end else if (READ_LAT == 1) begin
                    state_next = ST_RESP;
                end else begin
                    state_next = ST_RD_WAIT;
                    cnt_next   = CNT_W'(READ_LAT - 2);
                end
            end
            ST_RD_WAIT: begin
                if (cnt == '0) state_next = ST_RESP;
                else           cnt_next   = cnt - 1'b1;
            end
            ST_RESP: begin
                valid[sel_q] = 1'b1;
                rdata        = rd_pipe[READ_LAT-1];
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The winning request is captured once, so a port dropping req early cannot abort it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_last <= IDX_W'(NUM_PORTS - 1);
            sel_q   <= '0;
            we_q    <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
        end else if (state == ST_IDLE && any) begin
            rr_last <= pick_idx;
            sel_q   <= pick_idx;
            we_q    <= we[pick_idx];
            index_q <= addr[int'(pick_idx)*DATA_W + WORD_OFFSET +: ADDR_W];
            wdata_q <= wdata[int'(pick_idx)*DATA_W +: DATA_W];
        end
    end

    // Writes commit in the grant cycle, so any later read observes them.
    always_ff @(posedge clk) begin
        if (rst && state == ST_GNT) begin
            if (we_q) ram[index_q]  <= wdata_q;
            else      rd_pipe[0]    <= ram[index_q];
        end
        for (int k = 1; k < READ_LAT; k++) begin
            rd_pipe[k] <= rd_pipe[k-1];
        end
    end

`ifdef NTT_MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt[p] && perf_grants[p*PERF_W +: PERF_W] != '1)
                    perf_grants[p*PERF_W +: PERF_W] <= perf_grants[p*PERF_W +: PERF_W] + 1'b1;
            end
            if (|req && state != ST_IDLE && perf_stall != '1)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ntt_mem_arbiter.sv
// Scoreboard bench for ntt_mem_arbiter: directed transactions push expected grant/valid
// events; a negedge monitor pops and compares them as the DUT presents them.
module tb_ntt_mem_arbiter;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 10;
    localparam int READ_LAT  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_PORTS-1:0]  req;
    logic [NUM_PORTS-1:0]  we;
    logic [NUM_PORTS*64-1:0] addr;
    logic [NUM_PORTS*64-1:0] wdata;
    logic [NUM_PORTS-1:0]  gnt;
    logic [NUM_PORTS-1:0]  valid;
    logic [63:0]           rdata;
`ifdef NTT_MEM_ARB_PERF_EN
    logic [NUM_PORTS*32-1:0] perf_grants;
    logic [31:0]             perf_stall;
`endif

    always #5 clk = ~clk;

    ntt_mem_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ADDR_W    (ADDR_W),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .valid       (valid),
        .rdata       (rdata)
`ifdef NTT_MEM_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    typedef struct {
        bit          is_valid;
        int          port;
        logic [63:0] data;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   timeouts  = 0;
    bit   done      = 1'b0;
    int   cyc       = 0;
    int   last_gnt_cyc = 0;
    logic prev_rst  = 1'b1;

    // Queue one transaction; callers issue them in the hand-derived grant order.
    task automatic queueTxn(input int p, input bit is_wr, input logic [63:0] a,
                            input logic [63:0] d, input bit expect_valid, input int gap);
        exp_t e;
        req[p]            = 1'b1;
        we[p]             = is_wr;
        addr[p*64 +: 64]  = a;
        wdata[p*64 +: 64] = is_wr ? d : 64'h0;
        e.is_valid = 1'b0;
        e.port     = p;
        e.data     = 64'h0;
        e.gap      = gap;
        exp_q.push_back(e);
        if (!is_wr && expect_valid) begin
            e.is_valid = 1'b1;
            e.data     = d;
            e.gap      = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus();
        int budget;
        budget = 0;
        while (req != '0 && budget < 200) begin
            @(negedge clk);
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (req[p] && gnt[p]) req[p] = 1'b0;
            end
            budget++;
        end
        if (req != '0) begin
            timeouts++;
            req = '0;
        end
    endtask

    task automatic doReset();
        repeat (6) @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] exp_vec;
        cyc++;
        if (!rst && !prev_rst) begin
            checkOutput("reset_gnt", 64'(gnt), 64'h0);
            checkOutput("reset_valid", 64'(valid), 64'h0);
            checkOutput("reset_rdata", rdata, 64'h0);
        end
        prev_rst = rst;
        if (|gnt || |valid) begin
            checkOutput("exclusive_onehot",
                        {61'b0, $onehot0(gnt), $onehot0(valid), !(|gnt && |valid)}, 64'h7);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_event", {56'b0, gnt, valid}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                exp_vec = e.is_valid ? (64'h1 << e.port) : (64'h1 << (e.port + NUM_PORTS));
                checkOutput(e.is_valid ? "valid_port" : "gnt_port", {56'b0, gnt, valid}, exp_vec);
                if (e.is_valid) begin
                    checkOutput("rdata", rdata, e.data);
                    checkOutput("read_latency", 64'(cyc - last_gnt_cyc), 64'(READ_LAT));
                end else begin
                    if (e.gap != 0)
                        checkOutput("gnt_spacing", 64'(cyc - last_gnt_cyc), 64'(e.gap));
                    last_gnt_cyc = cyc;
                end
            end
        end
        if (done) begin
            checkOutput("queue_drained", 64'(exp_q.size()), 64'h0);
            checkOutput("wait_timeouts", 64'(timeouts), 64'h0);
`ifdef NTT_MEM_ARB_PERF_EN
            checkOutput("perf_grants2", 64'(perf_grants[2*32 +: 32]), 64'd10);
            checkOutput("perf_grants0", 64'(perf_grants[0 +: 32]), 64'd10);
            checkOutput("perf_stall_nonzero", 64'(perf_stall != 32'd0), 64'h1);
`endif
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        rst   = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        doReset();

        $display("[TB] write then read back on port 1");
        queueTxn(1, 1'b1, 64'h18, 64'hDEAD, 1'b0, 0);
        applyStimulus();
        queueTxn(1, 1'b0, 64'h18, 64'hDEAD, 1'b1, 2);
        applyStimulus();

        $display("[TB] all ports read together after reset");
        doReset();
        queueTxn(0, 1'b0, 64'h18,   64'hDEAD, 1'b1, 0);
        queueTxn(1, 1'b0, 64'h1F,   64'hDEAD, 1'b1, 4);
        queueTxn(2, 1'b0, 64'h2018, 64'hDEAD, 1'b1, 4);
        queueTxn(3, 1'b0, 64'h4018, 64'hDEAD, 1'b1, 4);
        applyStimulus();

        $display("[TB] address wrap on port 3");
        queueTxn(3, 1'b1, 64'h2000, 64'h5, 1'b0, 0);
        applyStimulus();
        queueTxn(3, 1'b0, 64'h0, 64'h5, 1'b1, 2);
        applyStimulus();

        $display("[TB] pending read after another port's write");
        queueTxn(2, 1'b1, 64'h40, 64'hA, 1'b0, 0);
        applyStimulus();
        queueTxn(0, 1'b0, 64'h40, 64'hA, 1'b1, 2);
        applyStimulus();

        $display("[TB] reset during read wait");
        queueTxn(1, 1'b0, 64'h40, 64'hA, 1'b0, 0);
        applyStimulus();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        queueTxn(0, 1'b0, 64'h18,   64'hDEAD, 1'b1, 0);
        queueTxn(1, 1'b0, 64'h40,   64'hA,    1'b1, 4);
        queueTxn(2, 1'b0, 64'h0,    64'h5,    1'b1, 4);
        queueTxn(3, 1'b0, 64'h2018, 64'hDEAD, 1'b1, 4);
        applyStimulus();

        $display("[TB] port 2 write burst against port 0 reads");
        doReset();
        for (int k = 0; k < 10; k++) begin
            queueTxn(0, 1'b0, 64'h40, 64'hA, 1'b1, 0);
            queueTxn(2, 1'b1, 64'h100 + 64'(8*k), 64'(k), 1'b0, 4);
            applyStimulus();
        end
        queueTxn(1, 1'b0, 64'h148, 64'd9, 1'b1, 0);
        applyStimulus();
        queueTxn(1, 1'b0, 64'h100, 64'd0, 1'b1, 0);
        applyStimulus();

        repeat (10) @(negedge clk);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
